// File: rtl/axi_resp_pkg.sv
// Shared types and widths for the AXI-style memory responder.
package axi_resp_pkg;
    localparam int CNT_W  = 4;
    localparam int WORD_W = 64;
    localparam int OFS_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;
endpackage

// File: rtl/axi_resp_mem.sv
// Word array with synchronous read and bit-masked write; contents are never reset.
module axi_resp_mem
    import axi_resp_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] wmask,
    input  logic [IDX_W-1:0]  ridx,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[widx] <= (mem[widx] & ~wmask) | (wdata & wmask);
        rdata <= mem[ridx];
    end
endmodule

// File: rtl/axi_mem_resp.sv
// Single-outstanding memory responder with programmable read/write latency.
// Optional AXI_RESP_ERR_EN adds ram_err_o and out-of-range address checking.
module axi_mem_resp
    import axi_resp_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_ren_i,
    input  logic [31:0]       ram_raddr_i,
    output logic [WORD_W-1:0] ram_rdata_o,
    output logic              ram_rready_o,
    input  logic              ram_wen_i,
    input  logic [31:0]       ram_waddr_i,
    input  logic [WORD_W-1:0] ram_wdata_i,
    input  logic [WORD_W-1:0] ram_wmask_i,
    output logic              ram_wready_o,
    output logic              ram_bvalid_o
`ifdef AXI_RESP_ERR_EN
    ,
    output logic              ram_err_o
`endif
);
    localparam int IDX_W = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_r, acc_w;
    logic               r_armed, w_armed;
    logic               wready_q;
    logic [IDX_W-1:0]   r_idx_q, w_idx_q;
    logic [WORD_W-1:0]  w_data_q, w_mask_q;
    logic [WORD_W-1:0]  mem_rdata;
    logic               mem_we;
    logic               r_oor_q, w_oor_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write has priority over a simultaneous read; the read stays pending.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_r   = 1'b0;
        acc_w   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ram_wen_i && w_armed) begin
                    acc_w   = 1'b1;
                    state_d = WR_WAIT;
                    cnt_d   = CNT_W'(WR_LAT);
                end else if (ram_ren_i && r_armed) begin
                    acc_r   = 1'b1;
                    state_d = RD_WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) state_d = RD_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WR_WAIT: begin
                if (cnt_q == '0) state_d = WR_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RD_RESP, WR_RESP: state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // A held level request must drop for one sample before it can be taken again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_armed  <= 1'b1;
            w_armed  <= 1'b1;
            wready_q <= 1'b0;
        end else begin
            wready_q <= acc_w;
            if (state_q == RD_RESP) r_armed <= 1'b0;
            else if (!ram_ren_i)    r_armed <= 1'b1;
            if (state_q == WR_RESP) w_armed <= 1'b0;
            else if (!ram_wen_i)    w_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_r)
            r_idx_q <= ram_raddr_i[OFS_W +: IDX_W];
        if (acc_w) begin
            w_idx_q  <= ram_waddr_i[OFS_W +: IDX_W];
            w_data_q <= ram_wdata_i;
            w_mask_q <= ram_wmask_i;
        end
    end

`ifdef AXI_RESP_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_oor_q <= 1'b0;
            w_oor_q <= 1'b0;
        end else begin
            if (acc_r) r_oor_q <= |ram_raddr_i[31:OFS_W+IDX_W];
            if (acc_w) w_oor_q <= |ram_waddr_i[31:OFS_W+IDX_W];
        end
    end
    assign ram_err_o = (state_q == RD_RESP && r_oor_q) || (state_q == WR_RESP && w_oor_q);
    logic unused_addr;
    assign unused_addr = ^{ram_raddr_i[OFS_W-1:0], ram_waddr_i[OFS_W-1:0]};
`else
    assign r_oor_q = 1'b0;
    assign w_oor_q = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{ram_raddr_i[31:OFS_W+IDX_W], ram_raddr_i[OFS_W-1:0],
                           ram_waddr_i[31:OFS_W+IDX_W], ram_waddr_i[OFS_W-1:0]};
`endif

    // Commit on the edge into WR_RESP; a reset on that edge drops the write.
    assign mem_we = rst && (state_q == WR_WAIT) && (cnt_q == '0) && !w_oor_q;

    axi_resp_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .widx  (w_idx_q),
        .wdata (w_data_q),
        .wmask (w_mask_q),
        .ridx  (r_idx_q),
        .rdata (mem_rdata)
    );

    assign ram_rready_o = (state_q == RD_RESP);
    assign ram_bvalid_o = (state_q == WR_RESP);
    assign ram_wready_o = wready_q;
    assign ram_rdata_o  = (state_q == RD_RESP && !r_oor_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_axi_mem_resp.sv
// Self-checking bench for axi_mem_resp: vector table, scoreboard, timing corner cases.
module tb_axi_mem_resp;
    localparam int DEPTH  = 4096;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ren_i, ram_wen_i;
    logic [31:0] ram_raddr_i, ram_waddr_i;
    logic [63:0] ram_rdata_o, ram_wdata_i, ram_wmask_i;
    logic        ram_rready_o, ram_wready_o, ram_bvalid_o;
`ifdef AXI_RESP_ERR_EN
    logic        ram_err_o;
`endif

    axi_mem_resp #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ram_ren_i    (ram_ren_i),
        .ram_raddr_i  (ram_raddr_i),
        .ram_rdata_o  (ram_rdata_o),
        .ram_rready_o (ram_rready_o),
        .ram_wen_i    (ram_wen_i),
        .ram_waddr_i  (ram_waddr_i),
        .ram_wdata_i  (ram_wdata_i),
        .ram_wmask_i  (ram_wmask_i),
        .ram_wready_o (ram_wready_o),
        .ram_bvalid_o (ram_bvalid_o)
`ifdef AXI_RESP_ERR_EN
        ,
        .ram_err_o    (ram_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } sb_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] data;   // write data, or expected read data
        logic [63:0] mask;
    } vec_t;

    sb_t  exp_q[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every read response pops the oldest expectation.
    always @(negedge clk) begin
        sb_t e;
        if (ram_rready_o) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", ram_rdata_o, e.data);
`ifdef AXI_RESP_ERR_EN
                chk("rd_err", {63'd0, ram_err_o}, {63'd0, e.err});
`endif
            end
        end else if (ram_rdata_o !== 64'd0) begin
            chk("rdata_idle", ram_rdata_o, 64'd0);
        end
    end

    // Called right after a posedge with the DUT idle and armed; returns likewise.
    task automatic do_read(input logic [31:0] a, input logic [63:0] exp, input logic exp_err);
        int n = 0;
        exp_q.push_back({exp_err, exp});
        ram_raddr_i = a;
        ram_ren_i   = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ram_rready_o && n < 40);
        chk("rd_latency", 64'(n), 64'(3 + RD_LAT));
        @(posedge clk); #1;
        ram_ren_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [63:0] m,
                            input logic exp_err);
        int n = 0;
        int wr_n = 0;
        ram_waddr_i = a;
        ram_wdata_i = d;
        ram_wmask_i = m;
        ram_wen_i   = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (ram_wready_o && wr_n == 0) wr_n = n;
        end while (!ram_bvalid_o && n < 40);
        chk("wready_latency", 64'(wr_n), 64'd2);
        chk("bvalid_latency", 64'(n), 64'(3 + WR_LAT));
`ifdef AXI_RESP_ERR_EN
        chk("wr_err", {63'd0, ram_err_o}, {63'd0, exp_err});
`else
        if (exp_err) chk("wr_err_unsupported", 64'd1, 64'd0);
`endif
        @(posedge clk); #1;
        ram_wen_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wr_n, b_n, r_n, pulses;

        tbl[0]  = '{1'b1, 32'h0000_0010, 64'h1122334455667788, '1};
        tbl[1]  = '{1'b0, 32'h0000_0010, 64'h1122334455667788, '0};
        tbl[2]  = '{1'b1, 32'h0000_0018, 64'hFFFFFFFFFFFFFFFF, '1};
        tbl[3]  = '{1'b1, 32'h0000_0018, 64'h0,                64'h00000000FFFFFFFF};
        tbl[4]  = '{1'b0, 32'h0000_0018, 64'hFFFFFFFF00000000, '0};
        tbl[5]  = '{1'b1, 32'h0000_0000, 64'hA5A5A5A5A5A5A5A5, '1};
        tbl[6]  = '{1'b0, 32'h0000_0007, 64'hA5A5A5A5A5A5A5A5, '0};
        tbl[7]  = '{1'b1, 32'h0000_7FF8, 64'hDEADBEEFCAFEF00D, '1};
        tbl[8]  = '{1'b0, 32'h0000_7FF8, 64'hDEADBEEFCAFEF00D, '0};
        tbl[9]  = '{1'b1, 32'h0000_0010, 64'h0,                64'hFF00FF00FF00FF00};
        tbl[10] = '{1'b0, 32'h0000_0010, 64'h0022004400660088, '0};
        tbl[11] = '{1'b1, 32'h0000_0020, 64'h1111111111111111, '1};
        tbl[12] = '{1'b0, 32'h0000_0020, 64'h1111111111111111, '0};

        rst = 1'b0;
        ram_ren_i = 1'b0; ram_wen_i = 1'b0;
        ram_raddr_i = '0; ram_waddr_i = '0; ram_wdata_i = '0; ram_wmask_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rready", {63'd0, ram_rready_o}, 64'd0);
        chk("rst_wready", {63'd0, ram_wready_o}, 64'd0);
        chk("rst_bvalid", {63'd0, ram_bvalid_o}, 64'd0);
        chk("rst_rdata", ram_rdata_o, 64'd0);
`ifdef AXI_RESP_ERR_EN
        chk("rst_err", {63'd0, ram_err_o}, 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].mask, 1'b0);
            else           do_read(tbl[i].addr, tbl[i].data, 1'b0);
        end

        // High address bits: wrap by default, error when checking is enabled.
`ifdef AXI_RESP_ERR_EN
        do_write(32'h8000_0010, 64'h1122334455667788, '1, 1'b1);
        do_read(32'h8000_0010, 64'h0, 1'b1);
        do_read(32'h0000_0010, 64'h0022004400660088, 1'b0);
        do_read(32'h0001_0000, 64'h0, 1'b1);
`else
        do_write(32'h8000_0010, 64'h1122334455667788, '1, 1'b0);
        do_read(32'h8000_0010, 64'h1122334455667788, 1'b0);
        do_read(32'h0000_0010, 64'h1122334455667788, 1'b0);
        do_read(32'h0001_0000, 64'hA5A5A5A5A5A5A5A5, 1'b0);
`endif

        // Simultaneous read and write to one address: write first, read sees new data.
        exp_q.push_back({1'b0, 64'h0123456789ABCDEF});
        ram_waddr_i = 32'h100; ram_raddr_i = 32'h100;
        ram_wdata_i = 64'h0123456789ABCDEF; ram_wmask_i = '1;
        ram_wen_i = 1'b1; ram_ren_i = 1'b1;
        n = 0; wr_n = 0; b_n = 0; r_n = 0;
        while (r_n == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (ram_wready_o && wr_n == 0) wr_n = n;
            if (ram_bvalid_o) begin b_n = n; ram_wen_i = 1'b0; end
            if (ram_rready_o) begin r_n = n; ram_ren_i = 1'b0; end
        end
        chk("sim_wready", 64'(wr_n), 64'd2);
        chk("sim_bvalid", 64'(b_n), 64'(3 + WR_LAT));
        chk("sim_rready", 64'(r_n), 64'(6 + WR_LAT + RD_LAT));
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Held level read: one response only until the request drops.
        exp_q.push_back({1'b0, 64'hFFFFFFFF00000000});
        ram_raddr_i = 32'h18;
        ram_ren_i = 1'b1;
        pulses = 0;
        repeat (3 + RD_LAT + 10) begin
            @(negedge clk);
            if (ram_rready_o) pulses++;
        end
        chk("held_pulses", 64'(pulses), 64'd1);
        @(posedge clk); #1;
        ram_ren_i = 1'b0;
        @(posedge clk); #1;
        do_read(32'h18, 64'hFFFFFFFF00000000, 1'b0);

        // Reset in the cycle after wready: write must be discarded.
        ram_waddr_i = 32'h20; ram_wdata_i = 64'h2222222222222222; ram_wmask_i = '1;
        ram_wen_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_wready", {63'd0, ram_wready_o}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        ram_wen_i = 1'b0;
        @(negedge clk);
        chk("rstw_bvalid_pre", {63'd0, ram_bvalid_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_bvalid", {63'd0, ram_bvalid_o}, 64'd0);
        chk("rstw_wready_after", {63'd0, ram_wready_o}, 64'd0);
        chk("rstw_rready", {63'd0, ram_rready_o}, 64'd0);
        chk("rstw_rdata", ram_rdata_o, 64'd0);
`ifdef AXI_RESP_ERR_EN
        chk("rstw_err", {63'd0, ram_err_o}, 64'd0);
`endif
        @(posedge clk); #1;
        do_read(32'h20, 64'h1111111111111111, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
